// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the boot-time instruction-memory loader.
//   loader_state_t : loader FSM state encoding
//   HDR_BYTES      : bytes in the little-endian word-count header
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   byte_idx_t     : index of a byte lane within an instruction word
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHECK state).
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx_t;

  // Encodings are pinned so the default and checksum builds agree on every
  // state they share.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_LO  = 3'd1,
    HDR_HI  = 3'd2,
    PAYLOAD = 3'd3,
    WRITE   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK   = 3'd5,
`endif
    DONE    = 3'd6,
    ERROR   = 3'd7
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake and the instruction-memory write bus.
//   byte_valid / byte_data / byte_ready : source -> loader byte stream
//   imem_we / imem_addr / imem_wdata    : loader -> instruction memory
// Modports:
//   master : the loader (consumes the stream, drives the memory bus)
//   slave  : the environment (drives the stream, observes the memory bus)
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 6
);

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             imem_we;
  logic [AW-1:0]    imem_addr;
  logic [WIDTH-1:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Packs a little-endian byte stream into instruction words.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : drop any partial word and restart at byte lane 0
//   push      : byte_in is consumed this cycle
//   byte_in   : stream byte
//   word_out  : assembled word (complete the cycle after the 4th push)
//   word_full : this push supplies the last byte of the word
// ---------------------------------------------------------------------------
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_full
);

  byte_idx_t        byte_idx;
  logic [WIDTH-1:0] shift_q;

  // Bytes enter at the top and shift down, so after four pushes the first
  // byte sits in bits [7:0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (push) begin
      byte_idx <= byte_idx + byte_idx_t'(1);
      shift_q  <= {byte_in, shift_q[WIDTH-1:8]};
    end
  end

  assign word_out  = shift_q;
  assign word_full = push && (byte_idx == byte_idx_t'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time loader: reads a 16-bit little-endian word count, then packs the
// following bytes into words written to instruction memory from address 0.
// Holds the core in reset while a session is in progress or has failed.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   start       : one-cycle request to begin a session (IDLE/DONE/ERROR)
//   bus         : byte stream in, instruction-memory write bus out
//   core_hold   : keep core in reset
//   busy        : session in progress
//   done, error : sticky outcome of the last session
//   word_count  : words written in the current or last session
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- a trailing byte must
// equal the XOR of all payload bytes for the session to succeed.
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH_IMEM = 64,
  localparam int AW         = $clog2(DEPTH_IMEM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   word_count
);

  localparam logic [AW:0] COUNT_ONE = {{AW{1'b0}}, 1'b1};

  loader_state_t    state_q, state_d;
  logic             ready_state;
  logic             xfer;
  logic             start_ok;
  logic [7:0]       hdr_lo_q;
  logic [15:0]      hdr_val;
  logic             hdr_bad;
  logic [AW:0]      n_words_q;
  logic             more_words;
  logic [AW-1:0]    last_addr_q;
  logic [WIDTH-1:0] last_wdata_q;
  logic [WIDTH-1:0] word_out;
  logic             word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign ready_state = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                       (state_q == PAYLOAD) || (state_q == CHECK);
`else
  assign ready_state = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                       (state_q == PAYLOAD);
`endif

  assign xfer     = bus.byte_valid && ready_state;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE) ||
                              (state_q == ERROR));

  // The header is judged in the same cycle its high byte arrives.
  assign hdr_val    = {bus.byte_data, hdr_lo_q};
  assign hdr_bad    = (hdr_val == 16'd0) || (hdr_val > 16'(DEPTH_IMEM));
  assign more_words = (word_count + COUNT_ONE) < n_words_q;

  word_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .push      (xfer && (state_q == PAYLOAD)),
    .byte_in   (bus.byte_data),
    .word_out  (word_out),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and all status/bus outputs decode from the current state.
  // Outside WRITE the memory bus replays the last word written.
  always_comb begin
    state_d        = state_q;
    bus.byte_ready = ready_state;
    bus.imem_we    = 1'b0;
    bus.imem_addr  = last_addr_q;
    bus.imem_wdata = last_wdata_q;
    core_hold      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = HDR_LO;
      end
      HDR_LO: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (xfer) state_d = HDR_HI;
      end
      HDR_HI: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (xfer) state_d = hdr_bad ? ERROR : PAYLOAD;
      end
      PAYLOAD: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        core_hold      = 1'b1;
        busy           = 1'b1;
        bus.imem_we    = 1'b1;
        bus.imem_addr  = word_count[AW-1:0];
        bus.imem_wdata = word_out;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = more_words ? PAYLOAD : CHECK;
`else
        state_d = more_words ? PAYLOAD : DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (xfer) state_d = (bus.byte_data == csum_q) ? DONE : ERROR;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start_ok) state_d = HDR_LO;
      end
      ERROR: begin
        error     = 1'b1;
        core_hold = 1'b1;
        if (start_ok) state_d = HDR_LO;
      end
      default: state_d = IDLE;
    endcase
  end

  // Header capture, word counting and the held copy of the last write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_lo_q     <= '0;
      n_words_q    <= '0;
      word_count   <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      if (start_ok) word_count <= '0;
      if (xfer && (state_q == HDR_LO)) hdr_lo_q <= bus.byte_data;
      if (xfer && (state_q == HDR_HI)) n_words_q <= hdr_val[AW:0];
      if (state_q == WRITE) begin
        word_count   <= word_count + COUNT_ONE;
        last_addr_q  <= word_count[AW-1:0];
        last_wdata_q <= word_out;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over payload bytes only; the header is not included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (xfer && (state_q == PAYLOAD)) begin
      csum_q <= csum_q ^ bus.byte_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. A behavioural model derives the
// expected words and outcome directly from the stream bytes.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] byteq_t [$];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          core_hold, busy, done, error;
  logic [AW:0]   word_count;

  int            n_cmp;
  int            n_fail;
  int            ready_in_write;
  logic [AW-1:0] cap_addr [$];
  logic [31:0]   cap_data [$];
  logic [31:0]   exp_data [$];
  bit            exp_err;
  int            exp_count;

  imem_loader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  imem_loader #(.WIDTH(WIDTH), .DEPTH_IMEM(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Record every memory write as the memory would capture it.
  always @(posedge clk) begin
    if (rst && bus.imem_we) begin
      cap_addr.push_back(bus.imem_addr);
      cap_data.push_back(bus.imem_wdata);
      if (bus.byte_ready) ready_in_write++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: header word count, LE word packing, XOR checksum.
  task automatic model_session(input byteq_t s);
    int         n;
    logic [7:0] x;
    logic [31:0] w;
    exp_data.delete();
    exp_err   = 1'b0;
    exp_count = 0;
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++) begin
        w = w | (32'(s[2 + 4*i + b]) << (8*b));
        x = x ^ s[2 + 4*i + b];
      end
      exp_data.push_back(w);
    end
    exp_count = n;
    if (CSUM) exp_err = (s[2 + 4*n] != x);
  endtask

  function automatic byteq_t add_csum(input byteq_t s, input bit bad);
    logic [7:0] x;
    byteq_t     r;
    r = s;
    if (CSUM) begin
      x = 8'h00;
      for (int i = 2; i < r.size(); i++) x = x ^ r[i];
      r.push_back(bad ? ~x : x);
    end
    return r;
  endfunction

  function automatic byteq_t case1_stream();
    logic [7:0] raw [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                             8'h93, 8'h05, 8'h20, 8'h00};
    byteq_t s;
    foreach (raw[i]) s.push_back(raw[i]);
    return add_csum(s, 1'b0);
  endfunction

  function automatic byteq_t rand_stream(input int n);
    byteq_t s;
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom_range(255)));
    return add_csum(s, 1'b0);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte (after optional idle gaps) and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit ok);
    if (gap_pct > 0) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(99) < gap_pct) begin
          bus.byte_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus.byte_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic run_session(input byteq_t s, input int gap_pct, output int timeouts);
    bit ok;
    bit fin;
    timeouts = 0;
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    foreach (s[i]) begin
      send_byte(s[i], gap_pct, ok);
      if (!ok) timeouts++;
    end
    fin = 1'b0;
    for (int c = 0; c < 10 && !fin; c++) begin
      @(negedge clk);
      if (done || error) fin = 1'b1;
      @(posedge clk); #1;
    end
    if (!fin) timeouts++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({core_hold, busy, done, error, bus.byte_ready, bus.imem_we} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b, want 000000",
               {core_hold, busy, done, error, bus.byte_ready, bus.imem_we});
    end
    n_cmp++;
    if ({word_count, bus.imem_addr, bus.imem_wdata} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: count %0h addr %0h data %0h, want all 0",
               word_count, bus.imem_addr, bus.imem_wdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    byteq_t s;
    bit     ok;
    s = case1_stream();
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    n_cmp++;
    if ({bus.byte_ready, busy, core_hold} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL start_latency: ready/busy/hold %b, want 111",
               {bus.byte_ready, busy, core_hold});
    end
    for (int i = 0; i < 10; i++) send_byte(s[i], 0, ok);
    n_cmp++;
    if ({bus.imem_we, bus.byte_ready} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL write_cycle: we/ready %b, want 10", {bus.imem_we, bus.byte_ready});
    end
    n_cmp++;
    if (bus.imem_wdata !== 32'h00200593 || bus.imem_addr !== 6'd1) begin
      n_fail++;
      $display("[TB] FAIL write_bus: addr %0d data %h, want 1 00200593",
               bus.imem_addr, bus.imem_wdata);
    end
    @(posedge clk); #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(s[10], 0, ok);
`endif
    n_cmp++;
    if ({done, error, core_hold, busy} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL basic_done: done/err/hold/busy %b, want 1000",
               {done, error, core_hold, busy});
    end
    n_cmp++;
    if (word_count !== 7'd2) begin
      n_fail++;
      $display("[TB] FAIL basic_count: got %0d, want 2", word_count);
    end
    n_cmp++;
    if (cap_data.size() != 2 || cap_addr[0] !== 6'd0 || cap_data[0] !== 32'h00100513 ||
        cap_addr[1] !== 6'd1 || cap_data[1] !== 32'h00200593) begin
      n_fail++;
      $display("[TB] FAIL basic_words: %0d writes, first %0d:%h, want 0:00100513 1:00200593",
               cap_data.size(), cap_addr[0], cap_data[0]);
    end
    n_cmp++;
    if (bus.imem_wdata !== 32'h00200593 || bus.imem_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL hold_bus: we %b data %h, want 0 00200593", bus.imem_we, bus.imem_wdata);
    end
  endtask

  task automatic test_header_errors();
    byteq_t s;
    bit     ok;
    int     to;
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h00, 0, ok);
    send_byte(8'h00, 0, ok);
    n_cmp++;
    if ({error, done, bus.byte_ready, core_hold, busy} !== 5'b10010) begin
      n_fail++;
      $display("[TB] FAIL hdr_zero: err/done/ready/hold/busy %b, want 10010",
               {error, done, bus.byte_ready, core_hold, busy});
    end
    n_cmp++;
    if (cap_data.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL hdr_zero_writes: got %0d, want 0", cap_data.size());
    end
    s = {8'h41, 8'h00};
    run_session(s, 0, to);
    model_session(s);
    n_cmp++;
    if (error !== exp_err || cap_data.size() != 0 || to != 0) begin
      n_fail++;
      $display("[TB] FAIL hdr_too_big: err %b writes %0d timeouts %0d, want %b 0 0",
               error, cap_data.size(), to, exp_err);
    end
  endtask

  task automatic test_full_depth();
    byteq_t s;
    int     to;
    s = rand_stream(64);
    run_session(s, 0, to);
    model_session(s);
    n_cmp++;
    if (to != 0 || cap_data.size() != exp_data.size()) begin
      n_fail++;
      $display("[TB] FAIL depth_writes: %0d writes %0d timeouts, want %0d 0",
               cap_data.size(), to, exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      n_cmp++;
      if (cap_data[i] !== exp_data[i] || cap_addr[i] !== 6'(i)) begin
        n_fail++;
        $display("[TB] FAIL depth_word%0d: %0d:%h, want %0d:%h",
                 i, cap_addr[i], cap_data[i], i, exp_data[i]);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || word_count !== 7'd64) begin
      n_fail++;
      $display("[TB] FAIL depth_done: done %b count %0d, want 1 64", done, word_count);
    end
  endtask

  task automatic test_random_stalls();
    byteq_t s;
    int     to;
    for (int it = 0; it < 5; it++) begin
      s = (it == 0) ? case1_stream() : rand_stream($urandom_range(1, 12));
      run_session(s, 40, to);
      model_session(s);
      n_cmp++;
      if (to != 0 || cap_data.size() != exp_data.size()) begin
        n_fail++;
        $display("[TB] FAIL stall%0d_writes: %0d writes %0d timeouts, want %0d 0",
                 it, cap_data.size(), to, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
        n_cmp++;
        if (cap_data[i] !== exp_data[i] || cap_addr[i] !== 6'(i)) begin
          n_fail++;
          $display("[TB] FAIL stall%0d_word%0d: %0d:%h, want %0d:%h",
                   it, i, cap_addr[i], cap_data[i], i, exp_data[i]);
        end
      end
      n_cmp++;
      if (done !== !exp_err || error !== exp_err || word_count !== 7'(exp_count)) begin
        n_fail++;
        $display("[TB] FAIL stall%0d_end: done %b err %b count %0d, want %b %b %0d",
                 it, done, error, word_count, !exp_err, exp_err, exp_count);
      end
    end
    n_cmp++;
    if (ready_in_write != 0) begin
      n_fail++;
      $display("[TB] FAIL ready_in_write: %0d cycles, want 0", ready_in_write);
    end
  endtask

  task automatic test_reset_midsession();
    byteq_t s;
    bit     ok;
    int     to;
    s = case1_stream();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(s[i], 0, ok);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({core_hold, busy, done, error, bus.byte_ready, bus.imem_we} !== 6'b0 ||
        word_count !== '0 || bus.imem_wdata !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: flags %b count %0d data %h, want 0 0 0",
               {core_hold, busy, done, error, bus.byte_ready, bus.imem_we},
               word_count, bus.imem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_session(s, 0, to);
    model_session(s);
    n_cmp++;
    if (to != 0 || done !== 1'b1 || cap_data.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL after_reset: done %b writes %0d timeouts %0d, want 1 2 0",
               done, cap_data.size(), to);
    end
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      n_cmp++;
      if (cap_data[i] !== exp_data[i]) begin
        n_fail++;
        $display("[TB] FAIL after_reset_word%0d: %h, want %h", i, cap_data[i], exp_data[i]);
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byteq_t s;
    int     to;
    s = case1_stream();
    void'(s.pop_back());
    s.push_back(8'h00);
    run_session(s, 0, to);
    model_session(s);
    n_cmp++;
    if (error !== exp_err || done !== !exp_err || cap_data.size() != 2 || to != 0) begin
      n_fail++;
      $display("[TB] FAIL csum_bad: err %b done %b writes %0d, want %b %b 2",
               error, done, cap_data.size(), exp_err, !exp_err);
    end
    n_cmp++;
    if (core_hold !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL csum_bad_hold: got %b, want 1", core_hold);
    end
  endtask
`endif

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    ready_in_write = 0;
    test_reset();
    test_basic();
    test_header_errors();
    test_full_depth();
    test_random_stalls();
    test_reset_midsession();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
